// File: rtl/tmr_cap_fifo_if.sv
// Consumer-side bus of the capture timestamp FIFO: flush/pop handshake, head
// data, occupancy/status flags and the per-event pulse.
interface tmr_cap_fifo_if #(
   parameter int CNT_WIDTH = 32,
   parameter int DEPTH     = 4
);
   logic                     clr_i;
   logic                     pop_i;
   logic [CNT_WIDTH-1:0]     dat_o;
   logic                     valid_o;
   logic                     full_o;
   logic [$clog2(DEPTH):0]   level_o;
   logic                     ovf_o;
   logic                     evt_o;

   modport master (
      output clr_i, pop_i,
      input  dat_o, valid_o, full_o, level_o, ovf_o, evt_o
   );

   modport slave (
      input  clr_i, pop_i,
      output dat_o, valid_o, full_o, level_o, ovf_o, evt_o
   );
endinterface

// File: rtl/tmr_cap_fifo.sv
// Input-capture timestamp unit: synchronises and glitch-filters a raw capture
// pin, qualifies edges, and stores the running timer count of each qualifying
// edge in a small first-word-fall-through FIFO.
module tmr_cap_fifo #(
   parameter int CNT_WIDTH = 32,
   parameter int DEPTH     = 4,
   parameter int FLT_LEN   = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 en_i,
   input  logic [1:0]           edge_sel_i,
   input  logic                 cap_i,
   input  logic [CNT_WIDTH-1:0] cnt_i,
   tmr_cap_fifo_if.slave        bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = (FLT_LEN > 1) ? $clog2(FLT_LEN) : 1;

   logic                 sync1, s;
   logic                 f;
   logic [CW-1:0]        c;
   logic                 upd, evt;
   logic                 pop_ok, push_ok, drop;
   logic                 full;
   logic [PW-1:0]        wp, rp;
   logic [LW-1:0]        level;
   logic                 ovf;
   logic [CNT_WIDTH-1:0] mem [DEPTH];

   // two-flop synchroniser for the asynchronous capture pin
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
      end else begin
         sync1 <= cap_i;
         s     <= sync1;
      end
   end

   // glitch filter: level follows s only after FLT_LEN consecutive differing cycles
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         f <= 1'b0;
         c <= '0;
      end else if (s == f) begin
         c <= '0;
      end else if (c == CW'(FLT_LEN - 1)) begin
         f <= s;
         c <= '0;
      end else begin
         c <= c + CW'(1);
      end
   end

   // edge qualification and FIFO push/pop arbitration
   always_comb begin
      upd     = (s != f) && (c == CW'(FLT_LEN - 1));
      evt     = en_i && upd && ((s && edge_sel_i[0]) || (!s && edge_sel_i[1]));
      full    = (level == LW'(DEPTH));
      pop_ok  = bus.pop_i && (level != '0);
      push_ok = evt && (!full || pop_ok);
      drop    = evt && full && !pop_ok;
   end

   // pointers, occupancy and sticky overflow; clr wins over a same-cycle event
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
         ovf   <= 1'b0;
      end else if (bus.clr_i) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
         ovf   <= 1'b0;
      end else begin
         if (push_ok) wp <= wp + PW'(1);
         if (pop_ok)  rp <= rp + PW'(1);
         if (push_ok && !pop_ok)      level <= level + LW'(1);
         else if (pop_ok && !push_ok) level <= level - LW'(1);
         if (drop) ovf <= 1'b1;
      end
   end

   // timestamp storage; contents need no reset since dat_o is masked when empty
   always_ff @(posedge clk_i) begin
      if (push_ok && !bus.clr_i) mem[wp] <= cnt_i;
   end

   // first-word-fall-through head and status outputs
   always_comb begin
      bus.valid_o = (level != '0);
      bus.dat_o   = bus.valid_o ? mem[rp] : '0;
      bus.full_o  = full;
      bus.level_o = level;
      bus.ovf_o   = ovf;
      bus.evt_o   = evt;
   end
endmodule
